pll_reset_ctrl: RTL and testbench

//  Drives the PLL's reset input and consumes its locked output. Clocked by the PLL

---
 rtl/pll_rst_pkg.sv | 41 ++++
 rtl/pll_reset_ctrl_bit_sync.sv | 40 ++++
 rtl/pll_reset_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
//
// Shared definitions for the PLL reset controller:
//   - state_t    : sequencer states, 3-bit encoding
//   - cnt_width(): width of the shared cycle counter, derived from the largest
//                  cycle parameter so that each terminal count fits
//   - CNT_W      : counter width for the default parameter set
// -----------------------------------------------------------------------------
package pll_rst_pkg;

  // Sequencer states.
  //   RESET     : PLL held in reset for a fixed pulse width
  //   WAIT_LOCK : PLL released, waiting for lock with a timeout
  //   STABLE    : lock seen, qualifying that it stays asserted
  //   RUN       : cores released; any lock loss re-arms the sequence
  //   FAIL      : retries exhausted; parked until rst or restart
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Counter width: $clog2 of the largest cycle parameter, plus one bit of
  // headroom so the terminal value (parameter - 1) always fits.
  function automatic int unsigned cnt_width(input int unsigned pulse,
                                            input int unsigned timeout,
                                            input int unsigned stable);
    int unsigned largest;
    largest = pulse;
    if (timeout > largest) largest = timeout;
    if (stable > largest) largest = stable;
    return $clog2(largest) + 1;
  endfunction

  // Counter width for the default parameters (16 / 50000 / 1024).
  localparam int unsigned CNT_W = cnt_width(16, 50000, 1024);

endpackage : pll_rst_pkg

// File: rtl/pll_reset_ctrl_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
//
// Multi-flop synchronizer for a single asynchronous level signal. All stages
// are cleared by the asynchronous reset, so the output reads 0 until the input
// has been sampled STAGES times after reset release.
//
// Parameters
//   STAGES : number of flops in the chain (>= 2)
//
// Ports
//   clk : destination clock, rising edge
//   rst : asynchronous reset, active-high
//   d   : asynchronous input
//   q   : synchronized output, STAGES clk edges behind d
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      // NOTE: non-blocking, so each stage takes its neighbour's value from
      // before this edge and the chain shifts by exactly one flop per clock.
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : bit_sync

// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Reset sequencer for a PLL and the cores it clocks. Runs on the PLL reference
// clock. Pulses the PLL reset, waits for lock with a timeout, requires lock to
// stay asserted for a qualification window, then releases core_rst. Lock loss
// while running re-arms the whole sequence. After MAX_RETRIES lock timeouts,
// the next timeout parks the sequencer in FAIL with lock_fail set.
//
// Parameters
//   RST_PULSE_CYCLES    : refclk cycles pll_rst is held per attempt (>= 1)
//   LOCK_TIMEOUT_CYCLES : cycles allowed in WAIT_LOCK before a retry
//   LOCK_STABLE_CYCLES  : consecutive locked cycles needed before RUN
//   MAX_RETRIES         : timeouts tolerated before FAIL
//   SYNC_STAGES         : synchronizer depth on pll_locked (>= 2)
//
// Ports
//   refclk     in   1  reference clock, rising edge
//   rst        in   1  asynchronous reset, active-high
//   pll_locked in   1  PLL lock indicator, asynchronous to refclk
//   restart    in   1  single-cycle pulse; restarts from RESET in any state
//   pll_rst    out  1  PLL reset, active-high, registered
//   core_rst   out  1  core reset, active-high, registered
//   lock_fail  out  1  sticky: retries exhausted
//   retry_cnt  out  4  lock timeouts in the current sequence
//   loss_cnt   out  8  saturating count of lock losses seen in RUN
//
// Timing
//   pll_locked rise to core_rst fall : SYNC_STAGES + LOCK_STABLE_CYCLES + 1
//   pll_locked fall in RUN to core_rst rise : SYNC_STAGES + 1
// -----------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // One counter is shared by RESET, WAIT_LOCK and STABLE; it is cleared on
  // every state change, so each state sees it start from zero.
  localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          fail_q, fail_d;
  logic          pll_rst_q, pll_rst_d;
  logic          core_rst_q, core_rst_d;
  logic          lk;

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      fail_q     <= 1'b0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      fail_q     <= fail_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    fail_d  = fail_q;

    if (restart) begin
      // restart overrides any same-cycle timeout or lock loss; loss_cnt is
      // history across sequences and is deliberately kept.
      state_d = RESET;
      cnt_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          // Lock is tested before the timeout, so a lock arriving on the
          // timeout cycle is accepted and no retry is counted.
          if (lk) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = RESET;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        STABLE: begin
          // Any dropout restarts the lock wait with a fresh timeout window.
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        RUN: begin
          if (!lk) begin
            state_d = RESET;
            cnt_d   = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end

        FAIL: begin
          fail_d = 1'b1;
        end

        default: begin
          state_d = RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and are glitch-free flop outputs.
    pll_rst_d  = (state_d == RESET) || (state_d == FAIL);
    core_rst_d = (state_d != RUN);
  end

  assign pll_rst   = pll_rst_q;
  assign core_rst  = core_rst_q;
  assign lock_fail = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule : pll_reset_ctrl

// File: tb/tb_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Directed scenarios with arithmetic expectations, followed by a randomized
// run compared cycle by cycle against a reference model. The model describes
// the sequence as phases with elapsed time in each phase and sees pll_locked
// through a SYNC-deep delay line. Outputs are sampled 1 ns after each rising
// edge; inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_pll_reset_ctrl;
  import pll_rst_pkg::*;

  localparam int RST_PULSE   = 4;
  localparam int TIMEOUT     = 20;
  localparam int STABLE_CYC  = 8;
  localparam int MAX_RETRIES = 2;
  localparam int SYNC        = 2;

  // Model phases.
  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_QUAL   = 2;
  localparam int P_RUN    = 3;
  localparam int P_GAVEUP = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       core_rst;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int tests = 0;
  int fails = 0;
  int exp_loss = 0;

  always #10 refclk = ~refclk;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES    (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE_CYC),
    .MAX_RETRIES         (MAX_RETRIES),
    .SYNC_STAGES         (SYNC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int            phase;
    int            elapsed;
    int            retries;
    int            losses;
    bit            gave_up;
    bit [SYNC-1:0] seen;     // pll_locked history, newest in bit 0
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase   = P_PULSE;
    r.elapsed = 0;
    r.retries = 0;
    r.losses  = 0;
    r.gave_up = 1'b0;
    r.seen    = '0;
    return r;
  endfunction

  function automatic model_t model_next(model_t cur, bit locked, bit rs);
    model_t n;
    bit     lkd;
    n      = cur;
    lkd    = cur.seen[SYNC-1];
    n.seen = {cur.seen[SYNC-2:0], locked};
    if (rs) begin
      n.phase   = P_PULSE;
      n.elapsed = 0;
      n.retries = 0;
      n.gave_up = 1'b0;
      return n;
    end
    case (cur.phase)
      P_PULSE: begin
        n.elapsed = cur.elapsed + 1;
        if (n.elapsed == RST_PULSE) begin
          n.phase   = P_WAIT;
          n.elapsed = 0;
        end
      end
      P_WAIT: begin
        if (lkd) begin
          n.phase   = P_QUAL;
          n.elapsed = 0;
        end else begin
          n.elapsed = cur.elapsed + 1;
          if (n.elapsed == TIMEOUT) begin
            n.elapsed = 0;
            if (cur.retries == MAX_RETRIES) begin
              n.phase   = P_GAVEUP;
              n.gave_up = 1'b1;
            end else begin
              n.retries = cur.retries + 1;
              n.phase   = P_PULSE;
            end
          end
        end
      end
      P_QUAL: begin
        if (!lkd) begin
          n.phase   = P_WAIT;
          n.elapsed = 0;
        end else begin
          n.elapsed = cur.elapsed + 1;
          if (n.elapsed == STABLE_CYC) begin
            n.phase   = P_RUN;
            n.elapsed = 0;
            n.retries = 0;
          end
        end
      end
      P_RUN: begin
        if (!lkd) begin
          n.phase   = P_PULSE;
          n.elapsed = 0;
          if (cur.losses < 255) n.losses = cur.losses + 1;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, pll_locked, restart);
  end

  // ---------------------------------------------------------------------------
  // Continuous assertions
  // ---------------------------------------------------------------------------
  always @(negedge refclk) begin
    if (!rst) begin
      tests++;
      assert (!$isunknown({pll_rst, lock_fail}))
      else begin
        fails++;
        $display("FAIL x_check: pll_rst=%b lock_fail=%b, required known values",
                 pll_rst, lock_fail);
      end
      if (core_rst === 1'b0) begin
        tests++;
        assert (dut.state_q == RUN)
        else begin
          fails++;
          $display("FAIL core_rst_outside_run: state=%0d with core_rst=0, required RUN",
                   dut.state_q);
        end
      end
    end
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 rst = 1'b1;
    #4;
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset pll_rst: got %b required 1", pll_rst); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL reset core_rst: got %b required 1", core_rst); end
    tests++; if (lock_fail !== 1'b0) begin fails++; $display("FAIL reset lock_fail: got %b required 0", lock_fail); end
    tests++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL reset retry_cnt: got %0d required 0", retry_cnt); end
    tests++; if (loss_cnt !== 8'd0) begin fails++; $display("FAIL reset loss_cnt: got %0d required 0", loss_cnt); end
  endtask

  // Lock arrives in cycle 10; core release at 10 + SYNC + STABLE + 1 = 21.
  task automatic test_first_lock();
    step();
    rst = 1'b0;
    for (int c = 0; c <= 26; c++) begin
      tests++;
      if (pll_rst !== 1'(c < RST_PULSE)) begin
        fails++; $display("FAIL first_lock pll_rst cycle %0d: got %b required %b", c, pll_rst, c < RST_PULSE);
      end
      tests++;
      if (core_rst !== 1'(c < 21)) begin
        fails++; $display("FAIL first_lock core_rst cycle %0d: got %b required %b", c, core_rst, c < 21);
      end
      if (c == 10) pll_locked = 1'b1;
      step();
    end
    tests++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL first_lock retry_cnt: got %0d required 0", retry_cnt); end
  endtask

  // Lock never arrives: a pulse every PULSE+TIMEOUT cycles, FAIL after the
  // third timeout, then held.
  task automatic test_timeout_fail();
    int period;
    int fail_at;
    period  = RST_PULSE + TIMEOUT;
    fail_at = period * (MAX_RETRIES + 1);
    rst        = 1'b1;
    pll_locked = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c <= fail_at + 200; c++) begin
      logic       e_prst;
      logic [3:0] e_retry;
      e_prst  = (c < fail_at) ? 1'((c % period) < RST_PULSE) : 1'b1;
      e_retry = (c < fail_at) ? 4'(c / period) : 4'(MAX_RETRIES);
      tests++;
      if (pll_rst !== e_prst) begin
        fails++; $display("FAIL timeout pll_rst cycle %0d: got %b required %b", c, pll_rst, e_prst);
      end
      tests++;
      if (retry_cnt !== e_retry) begin
        fails++; $display("FAIL timeout retry_cnt cycle %0d: got %0d required %0d", c, retry_cnt, e_retry);
      end
      tests++;
      if (lock_fail !== 1'(c >= fail_at)) begin
        fails++; $display("FAIL timeout lock_fail cycle %0d: got %b required %b", c, lock_fail, c >= fail_at);
      end
      tests++;
      if (core_rst !== 1'b1) begin
        fails++; $display("FAIL timeout core_rst cycle %0d: got %b required 1", c, core_rst);
      end
      step();
    end
  endtask

  // From FAIL: restart with lock already present -> RUN PULSE+1+STABLE cycles
  // after the restart edge.
  task automatic test_restart();
    restart    = 1'b1;
    pll_locked = 1'b1;
    step();
    restart = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      tests++;
      if (lock_fail !== 1'b0) begin fails++; $display("FAIL restart lock_fail cycle %0d: got %b required 0", c, lock_fail); end
      tests++;
      if (pll_rst !== 1'(c < RST_PULSE)) begin
        fails++; $display("FAIL restart pll_rst cycle %0d: got %b required %b", c, pll_rst, c < RST_PULSE);
      end
      tests++;
      if (core_rst !== 1'(c < 13)) begin
        fails++; $display("FAIL restart core_rst cycle %0d: got %b required %b", c, core_rst, c < 13);
      end
      tests++;
      if (loss_cnt !== 8'(exp_loss)) begin
        fails++; $display("FAIL restart loss_cnt cycle %0d: got %0d required %0d", c, loss_cnt, exp_loss);
      end
      step();
    end
  endtask

  // One-cycle lock dropout in RUN: core_rst up 3 cycles later, new pulse,
  // re-lock to RUN at +16.
  task automatic test_lock_loss();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    for (int d = 1; d <= 17; d++) begin
      logic e_core;
      e_core = (d < 3) ? 1'b0 : 1'(d < 16);
      tests++;
      if (core_rst !== e_core) begin
        fails++; $display("FAIL lock_loss core_rst +%0d: got %b required %b", d, core_rst, e_core);
      end
      tests++;
      if (pll_rst !== 1'(d >= 3 && d < 7)) begin
        fails++; $display("FAIL lock_loss pll_rst +%0d: got %b required %b", d, pll_rst, d >= 3 && d < 7);
      end
      tests++;
      if (loss_cnt !== 8'((d >= 3) ? exp_loss + 1 : exp_loss)) begin
        fails++; $display("FAIL lock_loss loss_cnt +%0d: got %0d required %0d", d, loss_cnt,
                          (d >= 3) ? exp_loss + 1 : exp_loss);
      end
      step();
    end
    exp_loss++;
  endtask

  // Lock dropout at stable count 5: back to WAIT_LOCK, then a full
  // qualification window; RUN at cycle 20 instead of 13.
  task automatic test_stable_glitch();
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int c = 0; c <= 21; c++) begin
      tests++;
      if (core_rst !== 1'(c < 20)) begin
        fails++; $display("FAIL stable_glitch core_rst cycle %0d: got %b required %b", c, core_rst, c < 20);
      end
      tests++;
      if (pll_rst !== 1'(c < RST_PULSE)) begin
        fails++; $display("FAIL stable_glitch pll_rst cycle %0d: got %b required %b", c, pll_rst, c < RST_PULSE);
      end
      if (c == 8) pll_locked = 1'b0;
      if (c == 9) pll_locked = 1'b1;
      step();
    end
  endtask

  // Lock reaching the synchronizer output on the timeout cycle wins: STABLE,
  // no retry, RUN at cycle 32.
  task automatic test_timeout_race();
    restart    = 1'b1;
    pll_locked = 1'b0;
    step();
    restart = 1'b0;
    for (int c = 0; c <= 33; c++) begin
      tests++;
      if (retry_cnt !== 4'd0) begin
        fails++; $display("FAIL timeout_race retry_cnt cycle %0d: got %0d required 0", c, retry_cnt);
      end
      tests++;
      if (pll_rst !== 1'(c < RST_PULSE)) begin
        fails++; $display("FAIL timeout_race pll_rst cycle %0d: got %b required %b", c, pll_rst, c < RST_PULSE);
      end
      tests++;
      if (core_rst !== 1'(c < 32)) begin
        fails++; $display("FAIL timeout_race core_rst cycle %0d: got %b required %b", c, core_rst, c < 32);
      end
      if (c == 21) pll_locked = 1'b1;
      step();
    end
  endtask

  // Asynchronous reset between edges while in RUN.
  task automatic test_async_reset();
    tests++;
    if (loss_cnt !== 8'(exp_loss)) begin
      fails++; $display("FAIL async_reset pre loss_cnt: got %0d required %0d", loss_cnt, exp_loss);
    end
    #5 rst = 1'b1;
    #1;
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL async_reset pll_rst: got %b required 1", pll_rst); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL async_reset core_rst: got %b required 1", core_rst); end
    tests++; if (loss_cnt !== 8'd0) begin fails++; $display("FAIL async_reset loss_cnt: got %0d required 0", loss_cnt); end
    tests++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL async_reset retry_cnt: got %0d required 0", retry_cnt); end
    exp_loss = 0;
    step();
    rst = 1'b0;
  endtask

  // Random lock waveform and occasional restart, compared to the model.
  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      logic e_prst;
      logic e_core;
      e_prst = (m.phase == P_PULSE) || (m.phase == P_GAVEUP);
      e_core = (m.phase != P_RUN);
      tests++;
      if (pll_rst !== e_prst || core_rst !== e_core || lock_fail !== m.gave_up ||
          retry_cnt !== 4'(m.retries) || loss_cnt !== 8'(m.losses)) begin
        fails++;
        $display("FAIL random cycle %0d: got prst=%b crst=%b fail=%b retry=%0d loss=%0d required prst=%b crst=%b fail=%b retry=%0d loss=%0d",
                 c, pll_rst, core_rst, lock_fail, retry_cnt, loss_cnt,
                 e_prst, e_core, m.gave_up, m.retries, m.losses);
      end
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      restart = ($urandom_range(0, 299) == 0);
      step();
    end
    restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_timeout_fail();
    test_restart();
    test_lock_loss();
    test_stable_glitch();
    test_timeout_race();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pll_reset_ctrl
